// File: rtl/clock_switch_controller_pkg.sv
// Shared types and helpers for the clock switch sequencer.
package clock_switch_controller_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    SETTLING = 1'b1
  } state_e;

  // The settle counter never needs fewer than one bit, even when SETTLE_CYCLES is 1.
  function automatic int settle_cnt_width(input int settle_cycles);
    int w;
    w = $clog2(settle_cycles);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic source_alive(input logic src, input logic alive_0, input logic alive_1);
    return src ? alive_1 : alive_0;
  endfunction

endpackage

// File: rtl/clock_switch_controller.sv
// Owns the clock_multiplexer select line: validates the target, drives select,
// then holds busy for a settle window while the mux synchronisers hand over.
//
// state    | meaning
// IDLE     | waiting for a request or a fallback condition
// SETTLING | select has changed, settle counter running, busy high
module clock_switch_controller
  import clock_switch_controller_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter bit DEFAULT_SELECT = 1'b0
) (
  input  logic clock,
  input  logic resetn,
  input  logic request_valid,
  input  logic request_select,
  output logic request_ready,
  input  logic clock_0_alive,
  input  logic clock_1_alive,
  input  logic fallback_enable,
  output logic select,
  output logic current_select,
  output logic busy,
  output logic done_pulse,
  output logic error_pulse,
  output logic fallback_pulse
);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("clock_switch_controller: SETTLE_CYCLES must be at least 1");
  end

  localparam int CNT_W = settle_cnt_width(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             select_q, select_d;
  logic             cur_sel_q, cur_sel_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             fallback_q, fallback_d;

  logic cur_alive;
  logic other_alive;
  logic req_alive;
  logic tgt_alive;
  logic fallback_cond;

  assign cur_alive     = source_alive(cur_sel_q, clock_0_alive, clock_1_alive);
  assign other_alive   = source_alive(~cur_sel_q, clock_0_alive, clock_1_alive);
  assign req_alive     = source_alive(request_select, clock_0_alive, clock_1_alive);
  assign tgt_alive     = source_alive(select_q, clock_0_alive, clock_1_alive);
  assign fallback_cond = fallback_enable & ~cur_alive & other_alive;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    select_d   = select_q;
    cur_sel_d  = cur_sel_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    fallback_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Fallback wins over a request presented in the same cycle.
        if (fallback_cond) begin
          select_d   = ~cur_sel_q;
          cnt_d      = CNT_LOAD;
          fallback_d = 1'b1;
          state_d    = SETTLING;
        end else if (request_valid) begin
          if (request_select == cur_sel_q) begin
            done_d = 1'b1;
          end else if (!req_alive) begin
            error_d = 1'b1;
          end else begin
            select_d = request_select;
            cnt_d    = CNT_LOAD;
            state_d  = SETTLING;
          end
        end
      end

      SETTLING: begin
        // Never revert select mid-switch; a dead target is only reported at completion.
        if (cnt_q == '0) begin
          cur_sel_d = select_q;
          done_d    = 1'b1;
          error_d   = ~tgt_alive;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      select_q   <= DEFAULT_SELECT;
      cur_sel_q  <= DEFAULT_SELECT;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      fallback_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      select_q   <= select_d;
      cur_sel_q  <= cur_sel_d;
      done_q     <= done_d;
      error_q    <= error_d;
      fallback_q <= fallback_d;
    end
  end

  assign request_ready  = (state_q == IDLE) & ~fallback_cond;
  assign select         = select_q;
  assign current_select = cur_sel_q;
  assign busy           = (state_q == SETTLING);
  assign done_pulse     = done_q;
  assign error_pulse    = error_q;
  assign fallback_pulse = fallback_q;

endmodule

// File: tb/tb_clock_switch_controller.sv
// Directed bench for clock_switch_controller with SETTLE_CYCLES=16, DEFAULT_SELECT=0.
module tb_clock_switch_controller;

  localparam int SETTLE = 16;

  logic clock = 1'b0;
  logic resetn;
  logic request_valid;
  logic request_select;
  logic request_ready;
  logic clock_0_alive;
  logic clock_1_alive;
  logic fallback_enable;
  logic select;
  logic current_select;
  logic busy;
  logic done_pulse;
  logic error_pulse;
  logic fallback_pulse;

  int checks = 0;
  int errors = 0;

  clock_switch_controller #(
    .SETTLE_CYCLES (SETTLE),
    .DEFAULT_SELECT(1'b0)
  ) dut (
    .clock          (clock),
    .resetn         (resetn),
    .request_valid  (request_valid),
    .request_select (request_select),
    .request_ready  (request_ready),
    .clock_0_alive  (clock_0_alive),
    .clock_1_alive  (clock_1_alive),
    .fallback_enable(fallback_enable),
    .select         (select),
    .current_select (current_select),
    .busy           (busy),
    .done_pulse     (done_pulse),
    .error_pulse    (error_pulse),
    .fallback_pulse (fallback_pulse)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag, input logic exp_sel);
    check({tag, ".select"}, select, exp_sel);
    check({tag, ".current_select"}, current_select, exp_sel);
    check({tag, ".busy"}, busy, 1'b0);
  endtask

  // Called right after the accepting edge; walks the remaining settle edges.
  task automatic run_settle(input string tag, input logic tgt, input logic exp_err);
    for (int i = 1; i < SETTLE; i++) begin
      step();
      check({tag, ".busy_mid"}, busy, 1'b1);
      check({tag, ".ready_mid"}, request_ready, 1'b0);
      check({tag, ".done_mid"}, done_pulse, 1'b0);
    end
    step();
    check({tag, ".busy_end"}, busy, 1'b0);
    check({tag, ".done_end"}, done_pulse, 1'b1);
    check({tag, ".error_end"}, error_pulse, exp_err);
    check({tag, ".current_end"}, current_select, tgt);
    check({tag, ".select_end"}, select, tgt);
  endtask

  task automatic do_switch(input string tag, input logic tgt);
    request_valid  = 1'b1;
    request_select = tgt;
    step();
    request_valid = 1'b0;
    check({tag, ".select_acc"}, select, tgt);
    check({tag, ".busy_acc"}, busy, 1'b1);
    check({tag, ".current_acc"}, current_select, ~tgt);
    run_settle(tag, tgt, 1'b0);
    step();
    check({tag, ".done_clear"}, done_pulse, 1'b0);
  endtask

  initial begin
    resetn          = 1'b0;
    request_valid   = 1'b0;
    request_select  = 1'b0;
    clock_0_alive   = 1'b1;
    clock_1_alive   = 1'b1;
    fallback_enable = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    // Reset state
    check_idle_outputs("reset", 1'b0);
    check("reset.ready", request_ready, 1'b1);
    check("reset.done", done_pulse, 1'b0);
    check("reset.error", error_pulse, 1'b0);
    check("reset.fallback", fallback_pulse, 1'b0);
    resetn = 1'b1;
    step();

    // Normal 0 -> 1 switch, busy for exactly SETTLE cycles
    request_valid  = 1'b1;
    request_select = 1'b1;
    #1;
    check("sw01.ready_pre", request_ready, 1'b1);
    step();
    request_valid = 1'b0;
    check("sw01.select_acc", select, 1'b1);
    check("sw01.busy_acc", busy, 1'b1);
    check("sw01.ready_acc", request_ready, 1'b0);
    check("sw01.current_acc", current_select, 1'b0);
    run_settle("sw01", 1'b1, 1'b0);
    step();
    check("sw01.done_clear", done_pulse, 1'b0);

    // Request to the already-selected source
    request_valid  = 1'b1;
    request_select = 1'b1;
    step();
    request_valid = 1'b0;
    check("same.done", done_pulse, 1'b1);
    check("same.busy", busy, 1'b0);
    check("same.select", select, 1'b1);
    step();
    check("same.done_clear", done_pulse, 1'b0);

    // Request to a dead target
    clock_0_alive  = 1'b0;
    request_valid  = 1'b1;
    request_select = 1'b0;
    step();
    request_valid = 1'b0;
    check("dead.error", error_pulse, 1'b1);
    check("dead.done", done_pulse, 1'b0);
    check_idle_outputs("dead", 1'b1);
    step();
    check("dead.error_clear", error_pulse, 1'b0);
    clock_0_alive = 1'b1;

    // Back to 0, then fallback to 1 when source 0 dies
    do_switch("sw10", 1'b0);
    fallback_enable = 1'b1;
    clock_0_alive   = 1'b0;
    request_valid   = 1'b1;
    request_select  = 1'b0;
    #1;
    check("fb.ready_blocked", request_ready, 1'b0);
    step();
    request_valid = 1'b0;
    check("fb.pulse", fallback_pulse, 1'b1);
    check("fb.done_none", done_pulse, 1'b0);
    check("fb.select", select, 1'b1);
    check("fb.busy", busy, 1'b1);
    run_settle("fb", 1'b1, 1'b0);
    step();
    check("fb.pulse_clear", fallback_pulse, 1'b0);
    fallback_enable = 1'b0;
    clock_0_alive   = 1'b1;

    // Target dies mid-switch: completes with done+error, then falls back
    do_switch("sw10b", 1'b0);
    request_valid  = 1'b1;
    request_select = 1'b1;
    step();
    request_valid = 1'b0;
    for (int i = 1; i < 5; i++) step();
    clock_1_alive = 1'b0;
    for (int i = 5; i < SETTLE; i++) begin
      step();
      check("die.select_held", select, 1'b1);
    end
    step();
    check("die.done", done_pulse, 1'b1);
    check("die.error", error_pulse, 1'b1);
    check("die.current", current_select, 1'b1);
    fallback_enable = 1'b1;
    #1;
    check("die.ready_blocked", request_ready, 1'b0);
    step();
    check("die.fb_pulse", fallback_pulse, 1'b1);
    check("die.fb_select", select, 1'b0);
    check("die.fb_done_none", done_pulse, 1'b0);
    check("die.fb_error_none", error_pulse, 1'b0);
    run_settle("diefb", 1'b0, 1'b0);

    // Both sources dead: no fallback, requests report error
    clock_0_alive = 1'b0;
    #1;
    check("both.ready", request_ready, 1'b1);
    step();
    check("both.no_fb", fallback_pulse, 1'b0);
    check("both.not_busy", busy, 1'b0);
    request_valid  = 1'b1;
    request_select = 1'b1;
    step();
    request_valid = 1'b0;
    check("both.error", error_pulse, 1'b1);
    check("both.select", select, 1'b0);
    fallback_enable = 1'b0;
    clock_0_alive   = 1'b1;
    clock_1_alive   = 1'b1;
    step();

    // Async reset during SETTLING
    request_valid  = 1'b1;
    request_select = 1'b1;
    step();
    request_valid = 1'b0;
    for (int i = 1; i < 8; i++) step();
    check("rst.busy_before", busy, 1'b1);
    check("rst.select_before", select, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    check("rst.select", select, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.current", current_select, 1'b0);
    check("rst.done", done_pulse, 1'b0);
    step();
    resetn = 1'b1;
    step();
    check("rst.done_after", done_pulse, 1'b0);
    check("rst.idle_ready", request_ready, 1'b1);
    do_switch("post_rst", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_switch_controller.md
Name: clock_switch_controller

Overview:
Sequencer that owns the select input of the glitch-free clock_multiplexer. It runs on an always-on reference clock and accepts switch requests through a valid/ready handshake. Before switching it checks that the target source is alive, then holds off further requests for a fixed settle window while the multiplexer synchronisers complete the handover. It can also fall back automatically to the other source when the active source dies.

Parameters:
SETTLE_CYCLES, 16, reference-clock cycles to hold busy after driving select; must be at least 1 (elaboration error otherwise). Size it to at least 2*STAGES*(slowest source period) expressed in reference cycles.
DEFAULT_SELECT, 0, value of select and current_select after reset.

Ports:
clock  input  1  always-on reference clock
resetn  input  1  asynchronous active-low reset
request_valid  input  1  switch request
request_select  input  1  target source, 0 or 1
request_ready  output  1  request accepted when valid and ready are both high on a rising edge
clock_0_alive  input  1  source 0 running, already synchronised to clock
clock_1_alive  input  1  source 1 running, already synchronised to clock
fallback_enable  input  1  enables automatic fallback
select  output  1  registered select to clock_multiplexer
current_select  output  1  last committed source
busy  output  1  switch in progress
done_pulse  output  1  one-cycle pulse, request or fallback completed
error_pulse  output  1  one-cycle pulse, target dead
fallback_pulse  output  1  one-cycle pulse, fallback started

Behaviour:
- Interface: one clock, clock; reset resetn is asynchronous and active-low.
- Reset values: state IDLE; select = current_select = DEFAULT_SELECT; busy = 0; all pulses 0; settle counter 0.
- States:
  - IDLE: waiting for a request or fallback condition.
  - SETTLING: select has changed; counter runs; busy = 1.
- alive(x) means clock_x_alive. The fallback condition F = fallback_enable & !alive(current_select) & alive(!current_select).
- request_ready = (state == IDLE) & !F. This is combinational from the state and the alive/enable inputs.
- Fallback has priority over requests. If F holds in IDLE at edge k:
  - select and target are set to !current_select.
  - fallback_pulse is high for the cycle after edge k.
  - The controller enters SETTLING.
- Request accepted at edge k, target t = request_select:
  - t == current_select: done_pulse for the cycle after edge k; no change; stays IDLE.
  - !alive(t): error_pulse for the cycle after edge k; no change; stays IDLE.
  - Otherwise: select = t after edge k; counter loads SETTLE_CYCLES-1; enter SETTLING.
- SETTLING:
  - The counter decrements once per cycle and request_ready = 0.
  - At the edge where the counter reads 0 (edge k+SETTLE_CYCLES): current_select = select, busy = 0, done_pulse high for one cycle, return to IDLE.
- Latency: busy is high for exactly SETTLE_CYCLES cycles. select leads current_select by SETTLE_CYCLES cycles.
- Target dies during SETTLING:
  - The switch still completes; select is never reverted mid-switch.
  - error_pulse is asserted together with done_pulse if alive(target) is low at completion.
  - If F then holds in IDLE, fallback proceeds normally on the following edge.
- Both sources dead: F is false, no action is taken, and requests to a dead target return error_pulse.
- Pulses never overlap across cases except done_pulse with error_pulse as described above.
- Asynchronous reset mid-SETTLING: everything returns immediately to reset values, so select jumps to DEFAULT_SELECT. The system integrator holds clock_multiplexer in reset together with this block.
- request_valid held high after acceptance is treated as a new request once ready reasserts.

Decomposition:
- Package clock_switch_controller_pkg holds:
  - state enum: IDLE, SETTLING.
  - function computing the counter width as $clog2(SETTLE_CYCLES) with a minimum of 1.
- No sub-module: the settle counter and FSM are inline. clock_multiplexer is instantiated by the parent alongside this block, not inside it.

Test Plan:
- Reset with DEFAULT_SELECT=0, SETTLE_CYCLES=16, both alive -> select=0, current_select=0, busy=0, request_ready=1, no pulses.
- Request select=1 accepted at edge k -> select=1 after edge k; busy high for 16 cycles; done_pulse after edge k+16; current_select=1; request_ready=0 throughout.
- Request select=1 while current_select=1 -> done_pulse next cycle; busy stays 0. Request select=0 with clock_0_alive=0 -> error_pulse next cycle; select unchanged.
- fallback_enable=1, current_select=0, drop clock_0_alive -> request_ready=0 that cycle; fallback_pulse next cycle; select=1; done_pulse 16 cycles later. A request asserted the same cycle is not accepted.
- Drop clock_1_alive at cycle 5 of a 0->1 switch -> switch completes at cycle 16 with done_pulse and error_pulse together. Next cycle, with fallback enabled, fallback to 0 starts.
- Assert resetn low at cycle 8 of SETTLING -> select=DEFAULT_SELECT immediately, busy=0, no done_pulse. After release, a new request completes normally.
